// File: rtl/can_rx_frame_fetcher.sv
// Drains received CAN frames from a can_top_raw register port into a first-word-fall-through word FIFO.
// Optional macro CAN_RX_TIMESTAMP_EN prepends a 32-bit timestamp word to every frame.
module can_rx_frame_fetcher #(
    parameter logic [7:0] IR_ADDR    = 8'd3,
    parameter logic [7:0] CMR_ADDR   = 8'd1,
    parameter logic [7:0] RXBUF_BASE = 8'd16,
    parameter int         RD_LAT     = 1,
    parameter int         FIFO_DEPTH = 32
) (
    input  logic        clk_i,
    input  logic        res_n,
    input  logic        irq_n_i,
    output logic        reg_re_o,
    output logic [7:0]  reg_addr_read_o,
    input  logic [31:0] reg_data_in_i,
    output logic        reg_we_o,
    output logic [7:0]  reg_addr_write_o,
    output logic [31:0] reg_data_out_o,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_sof,
    output logic        m_eof,
    output logic        busy,
    output logic [7:0]  ovf_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [1:0]    LAT_C   = 2'(RD_LAT);
`ifdef CAN_RX_TIMESTAMP_EN
    localparam logic [CW-1:0] HDR_WORDS = CW'(3);
`else
    localparam logic [CW-1:0] HDR_WORDS = CW'(2);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RD_IR, S_RD_INFO, S_RD_ID, S_RD_DATA, S_RELEASE, S_SETTLE
    } state_t;

    // Payload length in bytes from the info byte (RTR carries no data).
    function automatic logic [6:0] frame_len(input logic [7:0] info);
        logic [6:0] len;
        if (info[6]) begin
            len = 7'd0;
        end else if (!info[5]) begin
            len = (info[3:0] > 4'd8) ? 7'd8 : {3'd0, info[3:0]};
        end else begin
            case (info[3:0])
                4'd9:    len = 7'd12;
                4'd10:   len = 7'd16;
                4'd11:   len = 7'd20;
                4'd12:   len = 7'd24;
                4'd13:   len = 7'd32;
                4'd14:   len = 7'd48;
                4'd15:   len = 7'd64;
                default: len = {3'd0, info[3:0]};
            endcase
        end
        return len;
    endfunction

    state_t      state_q, state_d;
    logic        re_q, re_d;
    logic [7:0]  raddr_q, raddr_d;
    logic        we_q, we_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        pend_q, pend_d;
    logic [1:0]  lat_q, lat_d;
    logic [4:0]  ndata_q, ndata_d;
    logic [4:0]  k_q, k_d;
    logic [7:0]  ovf_q, ovf_d;
    logic        busy_q, busy_d;
`ifdef CAN_RX_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] ts_q, ts_d;
    logic [31:0] info_q, info_d;
`endif

    logic [33:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_s, pop_s;
    logic [33:0]   push_word_s;

    logic          rd_state_s, rd_done_s;
    logic [7:0]    rd_addr_s;
    logic [6:0]    len_s;
    logic [6:0]    len_rnd_s;
    logic [4:0]    ndata_s;
    logic [CW-1:0] nwords_s, free_s;

    // Register-port read engine, length decode and frame FSM.
    always_comb begin
        state_d     = state_q;
        re_d        = 1'b0;
        raddr_d     = raddr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pend_d      = pend_q;
        lat_d       = lat_q;
        ndata_d     = ndata_q;
        k_d         = k_q;
        ovf_d       = ovf_q;
        push_s      = 1'b0;
        push_word_s = {34{1'b0}};
        rd_done_s   = 1'b0;
`ifdef CAN_RX_TIMESTAMP_EN
        ts_cnt_d = ts_cnt_q + 32'd1;
        ts_d     = ts_q;
        info_d   = info_q;
`endif

        len_s     = frame_len(reg_data_in_i[7:0]);
        len_rnd_s = len_s + 7'd3;
        ndata_s   = len_rnd_s[6:2];
        nwords_s  = HDR_WORDS + CW'(ndata_s);
        free_s    = DEPTH_C - count_q;

        case (state_q)
            S_RD_IR:   rd_addr_s = IR_ADDR;
            S_RD_INFO: rd_addr_s = RXBUF_BASE;
            S_RD_ID:   rd_addr_s = RXBUF_BASE + 8'd1;
            S_RD_DATA: rd_addr_s = RXBUF_BASE + 8'd2 + {3'd0, k_q};
            default:   rd_addr_s = raddr_q;
        endcase
        rd_state_s = (state_q == S_RD_IR) || (state_q == S_RD_INFO) ||
                     (state_q == S_RD_ID) || (state_q == S_RD_DATA);

        // One read in flight: issue, count down the latency, then sample.
        if (rd_state_s) begin
            if (!pend_q) begin
                re_d    = 1'b1;
                raddr_d = rd_addr_s;
                pend_d  = 1'b1;
                lat_d   = LAT_C;
            end else if (lat_q == 2'd0) begin
                rd_done_s = 1'b1;
                pend_d    = 1'b0;
            end else begin
                lat_d = lat_q - 2'd1;
            end
        end else begin
            pend_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!irq_n_i) begin
                    state_d = S_RD_IR;
`ifdef CAN_RX_TIMESTAMP_EN
                    ts_d = ts_cnt_q;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_IR: begin
                if (rd_done_s) begin
                    state_d = reg_data_in_i[0] ? S_RD_INFO : S_IDLE;
                end else begin
                    state_d = S_RD_IR;
                end
            end
            S_RD_INFO: begin
                if (rd_done_s) begin
                    ndata_d = ndata_s;
                    k_d     = 5'd0;
                    if (free_s < nwords_s) begin
                        ovf_d   = (ovf_q == 8'hFF) ? ovf_q : ovf_q + 8'd1;
                        state_d = S_RELEASE;
                    end else begin
                        push_s = 1'b1;
`ifdef CAN_RX_TIMESTAMP_EN
                        push_word_s = {1'b1, 1'b0, ts_q};
                        info_d      = reg_data_in_i;
`else
                        push_word_s = {1'b1, 1'b0, reg_data_in_i};
`endif
                        state_d = S_RD_ID;
                    end
                end else begin
                    state_d = S_RD_INFO;
                end
            end
            S_RD_ID: begin
`ifdef CAN_RX_TIMESTAMP_EN
                // The info word follows the timestamp while the id read is issued.
                if (!pend_q) begin
                    push_s      = 1'b1;
                    push_word_s = {1'b0, 1'b0, info_q};
                end else begin
                    push_s = 1'b0;
                end
`endif
                if (rd_done_s) begin
                    push_s      = 1'b1;
                    push_word_s = {1'b0, (ndata_q == 5'd0), reg_data_in_i};
                    state_d     = (ndata_q == 5'd0) ? S_RELEASE : S_RD_DATA;
                end else begin
                    state_d = S_RD_ID;
                end
            end
            S_RD_DATA: begin
                if (rd_done_s) begin
                    push_s      = 1'b1;
                    push_word_s = {1'b0, (k_q == ndata_q - 5'd1), reg_data_in_i};
                    if (k_q == ndata_q - 5'd1) begin
                        state_d = S_RELEASE;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end else begin
                    state_d = S_RD_DATA;
                end
            end
            S_RELEASE: begin
                we_d    = 1'b1;
                waddr_d = CMR_ADDR;
                wdata_d = 32'h0000_0004;
                state_d = S_SETTLE;
            end
            // Gives the controller a cycle to drop its interrupt level.
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        pop_s    = (count_q != {CW{1'b0}}) && m_ready;
        wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control, port and FIFO state registers.
    always_ff @(posedge clk_i or negedge res_n) begin
        if (!res_n) begin
            state_q  <= S_IDLE;
            re_q     <= 1'b0;
            raddr_q  <= 8'd0;
            we_q     <= 1'b0;
            waddr_q  <= 8'd0;
            wdata_q  <= 32'd0;
            pend_q   <= 1'b0;
            lat_q    <= 2'd0;
            ndata_q  <= 5'd0;
            k_q      <= 5'd0;
            ovf_q    <= 8'd0;
            busy_q   <= 1'b0;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            re_q     <= re_d;
            raddr_q  <= raddr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            pend_q   <= pend_d;
            lat_q    <= lat_d;
            ndata_q  <= ndata_d;
            k_q      <= k_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef CAN_RX_TIMESTAMP_EN
    // Free-running timestamp and its per-frame capture.
    always_ff @(posedge clk_i or negedge res_n) begin
        if (!res_n) begin
            ts_cnt_q <= 32'd0;
            ts_q     <= 32'd0;
            info_q   <= 32'd0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
            info_q   <= info_d;
        end
    end
`endif

    // FIFO storage; entries are only meaningful below count_q.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= push_word_s;
        end
    end

    assign reg_re_o         = re_q;
    assign reg_addr_read_o  = raddr_q;
    assign reg_we_o         = we_q;
    assign reg_addr_write_o = waddr_q;
    assign reg_data_out_o   = wdata_q;
    assign m_valid          = (count_q != {CW{1'b0}});
    assign m_sof            = fifo_mem[rd_ptr_q][33];
    assign m_eof            = fifo_mem[rd_ptr_q][32];
    assign m_data           = fifo_mem[rd_ptr_q][31:0];
    assign busy             = busy_q;
    assign ovf_cnt          = ovf_q;

endmodule

// File: tb/tb_can_rx_frame_fetcher.sv
// Bench for can_rx_frame_fetcher: a register-space controller model plus a frame-level
// expectation model (read addresses, release writes, output words, overflow count).
module tb_can_rx_frame_fetcher;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        res_n, irq_n_i, m_ready;
    logic        reg_re_o, reg_we_o, m_valid, m_sof, m_eof, busy;
    logic [7:0]  reg_addr_read_o, reg_addr_write_o, ovf_cnt;
    logic [31:0] reg_data_in_i, reg_data_out_o, m_data;

    always #5 clk = ~clk;

    can_rx_frame_fetcher #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .res_n(res_n), .irq_n_i(irq_n_i),
        .reg_re_o(reg_re_o), .reg_addr_read_o(reg_addr_read_o), .reg_data_in_i(reg_data_in_i),
        .reg_we_o(reg_we_o), .reg_addr_write_o(reg_addr_write_o), .reg_data_out_o(reg_data_out_o),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof),
        .busy(busy), .ovf_cnt(ovf_cnt)
    );

    // Controller: read data is valid only in the single cycle RD_LAT=1 after the strobe.
    logic [31:0] regs [256];
    logic        rd_v = 1'b0;
    logic [7:0]  rd_a = 8'd0;
    always @(posedge clk) begin
        rd_v <= reg_re_o;
        rd_a <= reg_addr_read_o;
    end
    assign reg_data_in_i = rd_v ? regs[rd_a] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_rd [$];
    logic [39:0] exp_wr [$];
    logic [33:0] exp_out [$];
    int          exp_ovf = 0;
    int          fd_len [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic flag(input string nm, input logic [39:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%h required=none", nm, act);
    endtask

    // Frame-level model: what the fetcher must do with the current register contents.
    task automatic model_frame();
        int len, nd;
        logic [7:0] info;
        exp_rd.push_back(8'd3);
        if (regs[3][0] == 1'b0) return;
        exp_rd.push_back(8'd16);
        info = regs[16][7:0];
        if (info[6]) len = 0;
        else if (!info[5]) len = (info[3:0] > 4'd8) ? 8 : int'(info[3:0]);
        else len = fd_len[int'(info[3:0])];
        nd = (len + 3) / 4;
        if (DEPTH - exp_out.size() < 2 + nd) begin
            exp_ovf = (exp_ovf < 255) ? exp_ovf + 1 : 255;
        end else begin
            exp_out.push_back({1'b1, 1'b0, regs[16]});
            exp_rd.push_back(8'd17);
            exp_out.push_back({1'b0, (nd == 0), regs[17]});
            for (int k = 0; k < nd; k++) begin
                exp_rd.push_back(8'(18 + k));
                exp_out.push_back({1'b0, (k == nd - 1), regs[18 + k]});
            end
        end
        exp_wr.push_back({8'd1, 32'h0000_0004});
    endtask

    // Per-cycle comparison of every bus transaction and every output word.
    logic prev_re = 1'b0;
    always @(negedge clk) begin
        if (res_n) begin
            if (reg_re_o) begin
                if (prev_re) flag("re_pulse_width", 40'(reg_addr_read_o));
                if (exp_rd.size() == 0) flag("rd_unexpected", 40'(reg_addr_read_o));
                else chk("rd_addr", 40'(reg_addr_read_o), 40'(exp_rd.pop_front()));
            end
            if (reg_we_o) begin
                if (exp_wr.size() == 0) flag("wr_unexpected", {reg_addr_write_o, reg_data_out_o});
                else chk("wr", {reg_addr_write_o, reg_data_out_o}, exp_wr.pop_front());
            end
            if (m_valid && m_ready) begin
                if (exp_out.size() == 0) flag("out_unexpected", 40'({m_sof, m_eof, m_data}));
                else chk("out_word", 40'({m_sof, m_eof, m_data}), 40'(exp_out.pop_front()));
            end
        end
        prev_re = reg_re_o & res_n;
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Raise the interrupt, drop it on the release write (or the IR read), then wait for drain.
    task automatic go(input bit wait_we);
        int n;
        irq_n_i = 1'b0;
        n = 0;
        while (!(wait_we ? reg_we_o : reg_re_o) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) flag("timeout_strobe", 40'(n));
        irq_n_i = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) flag("timeout_idle", 40'(n));
        n = 0;
        while (m_ready && exp_out.size() != 0 && n < 60) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("rd_left", 40'(exp_rd.size()), 40'd0);
        chk("wr_left", 40'(exp_wr.size()), 40'd0);
        if (m_ready) chk("out_left", 40'(exp_out.size()), 40'd0);
        chk("ovf_cnt", 40'(ovf_cnt), 40'(exp_ovf));
    endtask

    task automatic load_fd15();
        regs[3]  = 32'h1;
        regs[16] = 32'h2F;
        regs[17] = 32'h0ABC_0001;
        for (int k = 0; k < 16; k++) regs[18 + k] = 32'hA000_0000 + 32'(k);
    endtask

    task automatic load_classic();
        regs[3]  = 32'h1;
        regs[16] = 32'h08;
        regs[17] = 32'h123;
        regs[18] = 32'h1122_3344;
        regs[19] = 32'h5566_7788;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 32'h0;
        res_n = 1'b0; irq_n_i = 1'b1; m_ready = 1'b1;
        repeat (2) step();
        chk("rst_re", 40'(reg_re_o), 40'd0);
        chk("rst_we", 40'(reg_we_o), 40'd0);
        chk("rst_valid", 40'(m_valid), 40'd0);
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_ovf", 40'(ovf_cnt), 40'd0);
        chk("rst_addrs", {16'd0, reg_addr_read_o, reg_addr_write_o, 8'd0}, 40'd0);
        chk("rst_wdata", 40'(reg_data_out_o), 40'd0);
        res_n = 1'b1;
        repeat (2) step();

        // Classical 8-byte frame.
        load_classic();
        model_frame();
        chk("pin_t1_n", 40'(exp_out.size()), 40'd4);
        chk("pin_t1_w0", 40'(exp_out[0]), {6'd0, 2'b10, 32'h0000_0008});
        chk("pin_t1_w1", 40'(exp_out[1]), {6'd0, 2'b00, 32'h0000_0123});
        chk("pin_t1_w3", 40'(exp_out[3]), {6'd0, 2'b01, 32'h5566_7788});
        chk("pin_t1_rd", {exp_rd[0], exp_rd[1], exp_rd[2], exp_rd[3], exp_rd[4]}, 40'h03_10_11_12_13);
        go(1'b1);

        // RTR with DLC 15: info and id only.
        regs[16] = 32'h4F;
        regs[17] = 32'h0000_0456;
        model_frame();
        chk("pin_t2_n", 40'(exp_out.size()), 40'd2);
        chk("pin_t2_w1", 40'(exp_out[1]), {6'd0, 2'b01, 32'h0000_0456});
        go(1'b1);

        // FD with DLC 15: 64 bytes, 16 data reads.
        load_fd15();
        model_frame();
        chk("pin_t3_n", 40'(exp_out.size()), 40'd18);
        chk("pin_t3_rd", {exp_rd[3], exp_rd[18], 24'd0}, {8'd18, 8'd33, 24'd0});
        go(1'b1);

        // Interrupt from another source: IR read only.
        regs[3] = 32'h4;
        model_frame();
        chk("pin_t4_n", 40'(exp_rd.size() + exp_wr.size() + exp_out.size()), 40'd1);
        go(1'b0);

        // Consumer stalled: second 18-word frame cannot fit and is dropped.
        m_ready = 1'b0;
        load_fd15();
        model_frame();
        go(1'b1);
        regs[17] = 32'h0ABC_0002;
        model_frame();
        chk("pin_t5_ovf", 40'(exp_ovf), 40'd1);
        go(1'b1);
        chk("t5_valid", 40'(m_valid), 40'd1);
        m_ready = 1'b1;
        begin
            int n = 0;
            while (exp_out.size() != 0 && n < 60) begin step(); n++; end
        end
        repeat (2) step();
        chk("t5_drained", 40'({exp_out.size(), m_valid}), 40'd0);

        // Reset in the middle of the data phase.
        load_fd15();
        model_frame();
        irq_n_i = 1'b0;
        begin
            int n = 0;
            while (!(reg_re_o && reg_addr_read_o == 8'd20) && n < 100) begin step(); n++; end
            if (n >= 100) flag("timeout_t6", 40'(n));
        end
        res_n = 1'b0;
        irq_n_i = 1'b1;
        #1;
        chk("t6_valid", 40'(m_valid), 40'd0);
        chk("t6_busy", 40'(busy), 40'd0);
        chk("t6_re", 40'(reg_re_o), 40'd0);
        exp_rd.delete();
        exp_wr.delete();
        exp_out.delete();
        exp_ovf = 0;
        repeat (2) step();
        res_n = 1'b1;
        repeat (8) step();
        chk("t6_ovf", 40'(ovf_cnt), 40'd0);
        load_classic();
        regs[19] = 32'h99AA_BBCC;
        model_frame();
        go(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/can_rx_frame_fetcher.md
Name: can_rx_frame_fetcher

Overview:
Host-side drain engine for one can_top_raw controller. It sits directly downstream of the controller's register port. It reacts to the receive interrupt, reads the received frame out of the RX buffer window and releases the buffer. It then streams the frame as 32-bit words into an internal FIFO for the consumer (bus bridge / checker).

Parameters:
IR_ADDR, 8'd3, interrupt register address; bit0 = RI (receive interrupt)
CMR_ADDR, 8'd1, command register address; bit2 = RRB (release receive buffer)
RXBUF_BASE, 8'd16, address of the first RX buffer word
RD_LAT, 1, cycles from reg_re_o pulse to valid reg_data_in_i (1..3)
FIFO_DEPTH, 32, output FIFO depth in words (power of two, >= 18)

Ports:
clk_i  in  1  system clock
res_n  in  1  asynchronous active-low reset
irq_n_i  in  1  controller irq_on, active low, level
reg_re_o  out  1  register read strobe, one cycle
reg_addr_read_o  out  8  read address
reg_data_in_i  in  32  controller reg_data_out
reg_we_o  out  1  register write strobe, one cycle
reg_addr_write_o  out  8  write address
reg_data_out_o  out  32  write data
m_valid  out  1  output word valid
m_ready  in  1  consumer accepts word
m_data  out  32  output word
m_sof  out  1  marks the first word of a frame
m_eof  out  1  marks the last word of a frame
busy  out  1  FSM not in IDLE
ovf_cnt  out  8  frames dropped for lack of FIFO space, saturating

Behaviour:
- Reset (async, res_n=0): FSM=IDLE; reg_re_o, reg_we_o, m_valid, busy = 0; addresses and reg_data_out_o = 0; FIFO empty; ovf_cnt = 0. Reset mid-frame discards the partial frame, and no release write is issued.
- Read handshake: reg_re_o high exactly 1 cycle with reg_addr_read_o stable. Data is sampled exactly RD_LAT cycles later. Only one read is outstanding at a time.
- Write handshake: reg_we_o high exactly 1 cycle with address and data stable. The strobe deasserts the next cycle, and the address is held.
- FSM states:
  - IDLE: leave when irq_n_i=0 is sampled, go to RD_IR.
  - RD_IR: read IR_ADDR. If bit0=0, go to IDLE (another interrupt source). Otherwise go to RD_INFO.
  - RD_INFO: read RXBUF_BASE. Info word: [7]=FF (extended), [6]=RTR, [5]=FDF, [3:0]=DLC.
  - Length decode:
    - RTR=1: len=0.
    - FDF=0: len=min(DLC,8).
    - FDF=1: DLC 0-8 map to 0-8; 9..15 map to 12,16,20,24,32,48,64.
  - Word count: nwords = 2 + ceil(len/4), so 2..18.
  - Space check: if FIFO free < nwords, increment ovf_cnt (saturate at 255) and go to RELEASE without pushing. Otherwise push the info word (m_sof=1) and go to RD_ID.
  - RD_ID: read RXBUF_BASE+1 and push it. If nwords==2 mark it m_eof and go to RELEASE; else go to RD_DATA.
  - RD_DATA: read RXBUF_BASE+2+k for k=0..nwords-3 and push each word. The last one is marked m_eof. Unused bytes of the last word pass through as read.
  - RELEASE: write CMR_ADDR with 32'h4. Then go to IDLE, but wait one cycle before sampling irq_n_i so the deasserting level is not re-detected.
- The FIFO stores {sof, eof, data} and supports first-word fall-through.
  - m_valid = !empty.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop is allowed when full.
  - The space check guarantees no push ever finds the FIFO full.
- Frames never interleave. Word order is strictly info, id, data0..n.
- irq_n_i that deasserts mid-fetch is ignored; the frame completes.

Optional Feature:
Macro CAN_RX_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running counter (reset 0, wraps) is latched on the IDLE-to-RD_IR transition.
  - The latched value is pushed as an extra first word with m_sof=1, before the info word; the info word then has m_sof=0.
  - nwords becomes 3..19, so FIFO_DEPTH must be >= 19.
- Undefined: no counter and no extra word.

Test Plan:
1. irq_n_i low, IR=0x01, info=0x08, id=0x123, data words 0x11223344 / 0x55667788. Expect reads at 3,16,17,18,19, then a write of 0x4 to addr 1. Expect 4 words out: sof on 0x08, eof on 0x55667788.
2. Info=0x4F (RTR, DLC15). Expect exactly 2 words (info + id, eof on id) and no RXBUF_BASE+2 read.
3. Info=0x2F (FD, DLC15). Expect 16 data reads at 18..33, 18 words out, and a release write after the last read.
4. IR=0x04 (RI clear). Expect a return to IDLE with no RX buffer reads, no write and no output.
5. Hold m_ready=0 with FIFO_DEPTH=32 and send two 18-word frames. Expect the first frame accepted, the second dropped, ovf_cnt=1, and both released.
6. Assert res_n=0 during RD_DATA. Expect m_valid=0, FIFO empty and busy=0 immediately; after release, the next irq frame is fetched cleanly.
